fft_sample_framer: RTL and testbench

//  Upstream stage of FFT_Butterfly. Gathers a serial stream of real audio samples into one buffer_size frame.

---
 rtl/fft_sample_framer_if.sv | 30 +++
 rtl/fft_sample_framer.sv | 138 +++++++++++++
 tb/tb_fft_sample_framer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sample_framer_if.sv
// Handshake/data bundle between the sample source, fft_sample_framer and the butterfly consumer.
// master = source/consumer side, slave = framer side.
interface fft_sample_framer_if #(
    parameter int buffer_size = 32,
    parameter int sample_size = 32
);
    localparam int HW = buffer_size * sample_size / 2;

    logic                   flush;
    logic [sample_size-1:0] in_sample;
    logic                   in_valid;
    logic                   in_ready;
    logic                   frame_valid;
    logic                   frame_ready;
    logic [HW-1:0]          even_real;
    logic [HW-1:0]          even_imag;
    logic [HW-1:0]          odd_real;
    logic [HW-1:0]          odd_imag;
    logic [15:0]            frame_count;

    modport master (
        output flush, in_sample, in_valid, frame_ready,
        input  in_ready, frame_valid, even_real, even_imag, odd_real, odd_imag, frame_count
    );

    modport slave (
        input  flush, in_sample, in_valid, frame_ready,
        output in_ready, frame_valid, even_real, even_imag, odd_real, odd_imag, frame_count
    );
endinterface

// File: rtl/fft_sample_framer.sv
// Collects a serial real-sample stream into one frame, split radix-2 DIT into even/odd slots.
// FFT_FRAMER_DOUBLE_BUFFER_EN selects a ping-pong pair of banks; undefined gives a single bank.
module fft_sample_framer #(
    parameter int buffer_size = 32,
    parameter int sample_size = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    fft_sample_framer_if.slave bus
);
    localparam int unsigned W    = $clog2(buffer_size);
    localparam logic [W-1:0] LAST = W'(buffer_size - 1);

    typedef enum logic {FILL, HOLD} state_e;

    state_e                 state_q;
    logic [W-1:0]           wr_idx_q, wr_idx_d;
    logic                   in_ready_q;
    logic                   frame_valid_q;
    logic [15:0]            frame_count_q;
    logic                   accept, last_acc, xfer;
    logic [sample_size-1:0] rd_data [buffer_size];

`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
    logic [sample_size-1:0] mem_q [2][buffer_size];
    logic                   fill_sel_q, out_sel_q;
`else
    logic [sample_size-1:0] mem_q [buffer_size];
`endif

    always_comb begin
        bus.in_ready = in_ready_q & ~bus.flush;
        accept       = bus.in_valid & bus.in_ready;
        last_acc     = accept & (wr_idx_q == LAST);
        xfer         = frame_valid_q & bus.frame_ready;
        wr_idx_d     = wr_idx_q;
        if (bus.flush)   wr_idx_d = '0;
        else if (accept) wr_idx_d = wr_idx_q + W'(1);
    end

    // Sample storage, index order; cleared on reset so outputs never carry X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < buffer_size; i++)
                    mem_q[b][i] <= '0;
`else
            for (int unsigned i = 0; i < buffer_size; i++)
                mem_q[i] <= '0;
`endif
        end else if (accept) begin
`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
            mem_q[fill_sel_q][wr_idx_q] <= bus.in_sample;
`else
            mem_q[wr_idx_q] <= bus.in_sample;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
            fill_sel_q    <= 1'b0;
            out_sel_q     <= 1'b0;
`endif
        end else begin
            wr_idx_q <= wr_idx_d;
            if (xfer) frame_count_q <= frame_count_q + 16'd1;
`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
            unique case (state_q)
                FILL: if (last_acc) begin
                    state_q       <= HOLD;
                    frame_valid_q <= 1'b1;
                    out_sel_q     <= fill_sel_q;
                    fill_sel_q    <= ~fill_sel_q;
                end
                HOLD: begin
                    // in_ready_q low here means the fill bank is complete and waiting behind the held one.
                    if (last_acc) begin
                        if (xfer) begin
                            out_sel_q  <= fill_sel_q;
                            fill_sel_q <= ~fill_sel_q;
                        end else begin
                            in_ready_q <= 1'b0;
                        end
                    end else if (xfer) begin
                        if (!in_ready_q) begin
                            out_sel_q  <= fill_sel_q;
                            fill_sel_q <= ~fill_sel_q;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q       <= FILL;
                            frame_valid_q <= 1'b0;
                        end
                    end else if (bus.flush && !in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end
                end
            endcase
`else
            unique case (state_q)
                FILL: if (last_acc) begin
                    state_q       <= HOLD;
                    frame_valid_q <= 1'b1;
                    in_ready_q    <= 1'b0;
                end
                HOLD: if (xfer) begin
                    state_q       <= FILL;
                    frame_valid_q <= 1'b0;
                    in_ready_q    <= 1'b1;
                end
            endcase
`endif
        end
    end

`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
    always_comb rd_data = mem_q[out_sel_q];
`else
    always_comb rd_data = mem_q;
`endif

    for (genvar k = 0; k < buffer_size / 2; k++) begin : g_slot
        assign bus.even_real[k*sample_size +: sample_size] = rd_data[2*k];
        assign bus.odd_real[k*sample_size +: sample_size]  = rd_data[2*k+1];
    end

    assign bus.even_imag   = '0;
    assign bus.odd_imag    = '0;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed scoreboard bench for fft_sample_framer: accepted samples are queued and popped per delivered frame.
// Define FFT_FRAMER_DOUBLE_BUFFER_EN to include the ping-pong streaming step.
module tb_fft_sample_framer;
    localparam int N = 32;
    localparam int S = 32;
    localparam int H = N * S / 2;
`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fft_sample_framer_if #(.buffer_size(N), .sample_size(S)) bus ();
    fft_sample_framer #(.buffer_size(N), .sample_size(S)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [S-1:0] exp_q[$];
    logic [15:0]  exp_cnt = '0;
    logic [H-1:0] ee, eo;

    task automatic chk(input string tag, input logic [H-1:0] obs, input logic [H-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_frame();
        logic [S-1:0] v;
        ee = '0;
        eo = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (i[0]) eo[(i/2)*S +: S] = v;
            else      ee[(i/2)*S +: S] = v;
        end
    endtask

    task automatic check_frame(input string tag);
        pop_frame();
        chk({tag, "_even_real"}, bus.even_real, ee);
        chk({tag, "_odd_real"},  bus.odd_real,  eo);
        chk({tag, "_even_imag"}, bus.even_imag, '0);
        chk({tag, "_odd_imag"},  bus.odd_imag,  '0);
    endtask

    // Offer one sample and wait for acceptance; a transfer seen on the way is scored.
    task automatic offer(input logic [S-1:0] s);
        int unsigned n = 0;
        bus.in_sample = s;
        bus.in_valid  = 1'b1;
        #1;
        while (!bus.in_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", H'(bus.in_ready), H'(1));
        else exp_q.push_back(s);
        if (bus.frame_valid && bus.frame_ready) begin
            check_frame("xfer");
            exp_cnt++;
        end
        tick();
    endtask

    task automatic transfer();
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        exp_cnt++;
        chk("xfer_fv_low",  H'(bus.frame_valid), H'(0));
        chk("xfer_count",   H'(bus.frame_count), H'(exp_cnt));
        chk("xfer_inready", H'(bus.in_ready),    H'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_sample = '0;
        bus.in_valid = 1'b0;
        bus.frame_ready = 1'b0;
        repeat (3) tick();
        chk("rst_fv",      H'(bus.frame_valid), H'(0));
        chk("rst_inready", H'(bus.in_ready),    H'(1));
        chk("rst_count",   H'(bus.frame_count), H'(0));
        chk("rst_even",    bus.even_real,       '0);
        chk("rst_odd",     bus.odd_real,        '0);
        reset_n = 1'b1;
        tick();

        // 1: stream 0..31, frame_valid one cycle after the last
        for (int i = 0; i < N; i++) begin
            chk("t1_fv_early", H'(bus.frame_valid), H'(0));
            offer(S'(i));
        end
        bus.in_valid = 1'b0;
        chk("t1_fv", H'(bus.frame_valid), H'(1));
        check_frame("t1");
        chk("t1_count", H'(bus.frame_count), H'(0));

        // 2: hold stable, then hand off
        repeat (5) begin
            tick();
            chk("t2_fv",      H'(bus.frame_valid), H'(1));
            chk("t2_even",    bus.even_real,       ee);
            chk("t2_odd",     bus.odd_real,        eo);
            chk("t2_inready", H'(bus.in_ready),    H'(DB));
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t2_flush_hold_fv", H'(bus.frame_valid), H'(1));
        chk("t2_flush_hold_even", bus.even_real, ee);
        transfer();

        // 3: partial frame discarded by flush
        for (int i = 0; i < 10; i++) offer(S'(200 + i));
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sample = S'(999);
        #1;
        chk("t3_flush_inready", H'(bus.in_ready), H'(0));
        exp_q.delete();
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("t3_fv_early", H'(bus.frame_valid), H'(0));
            offer(S'(100 + i));
        end
        bus.in_valid = 1'b0;
        chk("t3_fv", H'(bus.frame_valid), H'(1));
        check_frame("t3");
        chk("t3_even0",  H'(bus.even_real[S-1:0]),   H'(100));
        chk("t3_odd15",  H'(bus.odd_real[15*S +: S]), H'(131));
        transfer();

        // 4: extreme values stored bit-exact
        offer(32'hFFFF_FFFF);
        offer(32'h7FFF_FFFF);
        offer(32'h8000_0000);
        for (int i = 3; i < N; i++) offer(S'(i) * 32'h0101_0101);
        bus.in_valid = 1'b0;
        chk("t4_fv", H'(bus.frame_valid), H'(1));
        check_frame("t4");
        chk("t4_even0", H'(bus.even_real[S-1:0]),  H'(32'hFFFF_FFFF));
        chk("t4_odd0",  H'(bus.odd_real[S-1:0]),   H'(32'h7FFF_FFFF));
        chk("t4_even1", H'(bus.even_real[S +: S]), H'(32'h8000_0000));
        transfer();

        // 5: reset mid-frame loses partial data
        for (int i = 0; i < 20; i++) offer(S'(32'h500 + i));
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        tick();
        chk("t5_rst_fv",    H'(bus.frame_valid), H'(0));
        chk("t5_rst_count", H'(bus.frame_count), H'(0));
        chk("t5_rst_even",  bus.even_real,       '0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            chk("t5_fv_early", H'(bus.frame_valid), H'(0));
            offer(S'(32'h900 + i));
        end
        bus.in_valid = 1'b0;
        chk("t5_fv", H'(bus.frame_valid), H'(1));
        check_frame("t5");
        transfer();

`ifdef FFT_FRAMER_DOUBLE_BUFFER_EN
        // 6: back-to-back 64 samples into ping-pong banks
        reset_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2 * N; i++) begin
            if (i == 40) bus.frame_ready = 1'b1;
            chk("t6_inready", H'(bus.in_ready), H'(1));
            offer(S'(32'h7000 + i));
        end
        bus.in_valid = 1'b0;
        chk("t6_fv2", H'(bus.frame_valid), H'(1));
        if (bus.frame_valid && bus.frame_ready) begin
            check_frame("t6_f2");
            exp_cnt++;
        end
        tick();
        bus.frame_ready = 1'b0;
        chk("t6_fv_end",  H'(bus.frame_valid), H'(0));
        chk("t6_count",   H'(bus.frame_count), H'(16'd2));
        chk("t6_model",   H'(bus.frame_count), H'(exp_cnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
